// File: rtl/cond_flag_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cond_flag_unit
//  Purpose  : Execute-stage condition/flag unit. Holds the NZCV flags register
//             that feeds the condition checker. Uses the checker's
//             condition-passed result to gate the instruction's flag update,
//             register write, memory write and PC redirect. Registers the
//             gated controls into the Memory stage. Keeps saturating
//             executed/squashed instruction counters.
//  Ports    : clk, rst_n (async, active-low)
//             ValidE, Stall, Flush          - EX instruction status
//             CondE, CondEx                 - condition field / checker result
//             FlagWriteE, ALUFlagsE         - flag update enables / ALU flags
//             RegWriteE, MemWriteE, PCSrcE  - ungated EX controls
//             Flags                         - flags register {Z,C,N,V}
//             BranchTakenE                  - same-cycle PC redirect
//             RegWriteM, MemWriteM, PCSrcM  - registered gated controls
//             UndefErr                      - sticky undefined-condition flag
//             ExecCount, SquashCount        - saturating event counters
//  Revision : 1.0 - initial release
// ============================================================================
module cond_flag_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ValidE,
    input  logic             Stall,
    input  logic             Flush,
    input  logic [3:0]       CondE,
    input  logic             CondEx,
    input  logic [1:0]       FlagWriteE,
    input  logic [3:0]       ALUFlagsE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             PCSrcE,
    output logic [3:0]       Flags,
    output logic             BranchTakenE,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             PCSrcM,
    output logic             UndefErr,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SquashCount
);

    localparam logic [3:0] c_COND_UNDEF = 4'b1111;

    // Flags bit positions within {Z,C,N,V}
    localparam int c_Z = 3;
    localparam int c_C = 2;
    localparam int c_N = 1;
    localparam int c_V = 0;

    logic             w_advance;
    logic             w_undef;
    logic             w_exec;
    logic             w_squash;
    logic [3:0]       w_flags_next;

    logic [3:0]       r_flags;
    logic             r_regwrite_m;
    logic             r_memwrite_m;
    logic             r_pcsrc_m;
    logic             r_undef_err;
    logic [CNT_W-1:0] r_exec_cnt;
    logic [CNT_W-1:0] r_squash_cnt;

    // Flush dominates Stall: either one keeps the instruction from advancing.
    assign w_advance = ValidE & ~Stall & ~Flush;
    assign w_undef   = w_advance & (CondE == c_COND_UNDEF);
    // undef is evaluated first so an unknown CondEx cannot leak into exec
    // when the condition field is undefined (0 && X == 0).
    assign w_exec    = w_advance && !w_undef && CondEx;
    assign w_squash  = w_advance & ~w_exec;

    assign BranchTakenE = w_exec & PCSrcE;

    always_comb begin
        w_flags_next = r_flags;
        if (w_exec && FlagWriteE[1]) begin
            w_flags_next[c_N] = ALUFlagsE[c_N];
            w_flags_next[c_Z] = ALUFlagsE[c_Z];
        end
        if (w_exec && FlagWriteE[0]) begin
            w_flags_next[c_C] = ALUFlagsE[c_C];
            w_flags_next[c_V] = ALUFlagsE[c_V];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags      <= 4'b0000;
            r_regwrite_m <= 1'b0;
            r_memwrite_m <= 1'b0;
            r_pcsrc_m    <= 1'b0;
            r_undef_err  <= 1'b0;
            r_exec_cnt   <= '0;
            r_squash_cnt <= '0;
        end else begin
            r_flags      <= w_flags_next;
            // Non-executing cycles (stall, flush, fail, undef) insert a bubble.
            r_regwrite_m <= w_exec & RegWriteE;
            r_memwrite_m <= w_exec & MemWriteE;
            r_pcsrc_m    <= w_exec & PCSrcE;
            if (w_undef) begin
                r_undef_err <= 1'b1;
            end
            if (w_exec && (r_exec_cnt != '1)) begin
                r_exec_cnt <= r_exec_cnt + 1'b1;
            end
            if (w_squash && (r_squash_cnt != '1)) begin
                r_squash_cnt <= r_squash_cnt + 1'b1;
            end
        end
    end

    assign Flags       = r_flags;
    assign RegWriteM   = r_regwrite_m;
    assign MemWriteM   = r_memwrite_m;
    assign PCSrcM      = r_pcsrc_m;
    assign UndefErr    = r_undef_err;
    assign ExecCount   = r_exec_cnt;
    assign SquashCount = r_squash_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cond_flag_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cond_flag_unit
//  Purpose  : Self-checking bench for cond_flag_unit (CNT_W = 4) using a
//             table of directed vectors plus hand-written sequences for
//             counter saturation and asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cond_flag_unit;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             ValidE;
    logic             Stall;
    logic             Flush;
    logic [3:0]       CondE;
    logic             CondEx;
    logic [1:0]       FlagWriteE;
    logic [3:0]       ALUFlagsE;
    logic             RegWriteE;
    logic             MemWriteE;
    logic             PCSrcE;
    logic [3:0]       Flags;
    logic             BranchTakenE;
    logic             RegWriteM;
    logic             MemWriteM;
    logic             PCSrcM;
    logic             UndefErr;
    logic [CNT_W-1:0] ExecCount;
    logic [CNT_W-1:0] SquashCount;

    int n_cmp;
    int n_bad;

    cond_flag_unit #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ValidE       (ValidE),
        .Stall        (Stall),
        .Flush        (Flush),
        .CondE        (CondE),
        .CondEx       (CondEx),
        .FlagWriteE   (FlagWriteE),
        .ALUFlagsE    (ALUFlagsE),
        .RegWriteE    (RegWriteE),
        .MemWriteE    (MemWriteE),
        .PCSrcE       (PCSrcE),
        .Flags        (Flags),
        .BranchTakenE (BranchTakenE),
        .RegWriteM    (RegWriteM),
        .MemWriteM    (MemWriteM),
        .PCSrcM       (PCSrcM),
        .UndefErr     (UndefErr),
        .ExecCount    (ExecCount),
        .SquashCount  (SquashCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       valid, stall, flush;
        logic [3:0] cond;
        logic       condex;
        logic [1:0] fw;
        logic [3:0] alu;
        logic       rw, mw, pc;
        logic       br;          // expected BranchTakenE before the edge
        logic [3:0] flags;       // expected after the edge
        logic       rwm, mwm, pcm, und;
        logic [3:0] ec, sc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        ValidE     = v.valid;
        Stall      = v.stall;
        Flush      = v.flush;
        CondE      = v.cond;
        CondEx     = v.condex;
        FlagWriteE = v.fw;
        ALUFlagsE  = v.alu;
        RegWriteE  = v.rw;
        MemWriteE  = v.mw;
        PCSrcE     = v.pc;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".Flags"},       {28'd0, Flags}, 32'd0);
        chk({tag, ".RegWriteM"},   {31'd0, RegWriteM}, 32'd0);
        chk({tag, ".MemWriteM"},   {31'd0, MemWriteM}, 32'd0);
        chk({tag, ".PCSrcM"},      {31'd0, PCSrcM}, 32'd0);
        chk({tag, ".UndefErr"},    {31'd0, UndefErr}, 32'd0);
        chk({tag, ".ExecCount"},   {28'd0, ExecCount}, 32'd0);
        chk({tag, ".SquashCount"}, {28'd0, SquashCount}, 32'd0);
    endtask

    function automatic vec_t mk(
        input string n,
        input logic va, input logic st, input logic fl, input logic [3:0] cd,
        input logic cx, input logic [1:0] fw, input logic [3:0] alu,
        input logic rw, input logic mw, input logic pc,
        input logic br, input logic [3:0] fg, input logic rwm, input logic mwm,
        input logic pcm, input logic und, input logic [3:0] ec, input logic [3:0] sc);
        vec_t v;
        v.name = n; v.valid = va; v.stall = st; v.flush = fl; v.cond = cd;
        v.condex = cx; v.fw = fw; v.alu = alu; v.rw = rw; v.mw = mw; v.pc = pc;
        v.br = br; v.flags = fg; v.rwm = rwm; v.mwm = mwm; v.pcm = pcm;
        v.und = und; v.ec = ec; v.sc = sc;
        return v;
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;

        //               name        va st fl cond  cx    fw     alu      rw mw pc  br flags    rwm mwm pcm und ec     sc
        vecs.push_back(mk("adds",     1, 0, 0, 4'hE, 1,    2'b11, 4'b1010, 1, 0, 0,  0, 4'b1010, 1, 0, 0, 0, 4'd1, 4'd0));
        vecs.push_back(mk("condfail", 1, 0, 0, 4'h0, 0,    2'b11, 4'b0101, 1, 1, 1,  0, 4'b1010, 0, 0, 0, 0, 4'd1, 4'd1));
        vecs.push_back(mk("clrflags", 1, 0, 0, 4'hE, 1,    2'b11, 4'b0000, 0, 0, 0,  0, 4'b0000, 0, 0, 0, 0, 4'd2, 4'd1));
        vecs.push_back(mk("part_nz",  1, 0, 0, 4'hE, 1,    2'b10, 4'b1111, 0, 0, 0,  0, 4'b1010, 0, 0, 0, 0, 4'd3, 4'd1));
        vecs.push_back(mk("part_cv",  1, 0, 0, 4'h1, 1,    2'b01, 4'b0101, 0, 1, 0,  0, 4'b1111, 0, 1, 0, 0, 4'd4, 4'd1));
        vecs.push_back(mk("stall1",   1, 1, 0, 4'hE, 1,    2'b11, 4'b0000, 1, 1, 1,  0, 4'b1111, 0, 0, 0, 0, 4'd4, 4'd1));
        vecs.push_back(mk("stall2",   1, 1, 0, 4'hE, 1,    2'b11, 4'b0000, 1, 1, 1,  0, 4'b1111, 0, 0, 0, 0, 4'd4, 4'd1));
        vecs.push_back(mk("stall3",   1, 1, 0, 4'hE, 1,    2'b11, 4'b0000, 1, 1, 1,  0, 4'b1111, 0, 0, 0, 0, 4'd4, 4'd1));
        vecs.push_back(mk("advbr",    1, 0, 0, 4'hE, 1,    2'b11, 4'b0000, 1, 1, 1,  1, 4'b0000, 1, 1, 1, 0, 4'd5, 4'd1));
        vecs.push_back(mk("stflush",  1, 1, 1, 4'hE, 1,    2'b11, 4'b1111, 1, 1, 1,  0, 4'b0000, 0, 0, 0, 0, 4'd5, 4'd1));
        vecs.push_back(mk("flush",    1, 0, 1, 4'hE, 1,    2'b11, 4'b1111, 1, 1, 1,  0, 4'b0000, 0, 0, 0, 0, 4'd5, 4'd1));
        vecs.push_back(mk("invalid",  0, 0, 0, 4'hE, 1,    2'b11, 4'b1111, 1, 1, 1,  0, 4'b0000, 0, 0, 0, 0, 4'd5, 4'd1));
        vecs.push_back(mk("undef_x",  1, 0, 0, 4'hF, 1'bx, 2'b11, 4'b1111, 1, 1, 1,  0, 4'b0000, 0, 0, 0, 1, 4'd5, 4'd2));
        vecs.push_back(mk("postund",  1, 0, 0, 4'hE, 1,    2'b00, 4'b1111, 1, 0, 0,  0, 4'b0000, 1, 0, 0, 1, 4'd6, 4'd2));
        vecs.push_back(mk("undef_1",  1, 0, 0, 4'hF, 1,    2'b11, 4'b1111, 1, 1, 1,  0, 4'b0000, 0, 0, 0, 1, 4'd6, 4'd3));

        rst_n = 1'b0;
        drive(mk("idle", 0, 0, 0, 4'h0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 4'd0, 4'd0));
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk({vecs[i].name, ".BranchTakenE"}, {31'd0, BranchTakenE}, {31'd0, vecs[i].br});
            @(posedge clk);
            #1;
            chk({vecs[i].name, ".Flags"},       {28'd0, Flags},       {28'd0, vecs[i].flags});
            chk({vecs[i].name, ".RegWriteM"},   {31'd0, RegWriteM},   {31'd0, vecs[i].rwm});
            chk({vecs[i].name, ".MemWriteM"},   {31'd0, MemWriteM},   {31'd0, vecs[i].mwm});
            chk({vecs[i].name, ".PCSrcM"},      {31'd0, PCSrcM},      {31'd0, vecs[i].pcm});
            chk({vecs[i].name, ".UndefErr"},    {31'd0, UndefErr},    {31'd0, vecs[i].und});
            chk({vecs[i].name, ".ExecCount"},   {28'd0, ExecCount},   {28'd0, vecs[i].ec});
            chk({vecs[i].name, ".SquashCount"}, {28'd0, SquashCount}, {28'd0, vecs[i].sc});
        end

        // Saturation: ExecCount is 6 here; 20 more executions must stop at 15.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(mk("sat", 1, 0, 0, 4'hE, 1, 2'b11, 4'b1111, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0, 4'd0, 4'd0));
            @(posedge clk);
            #1;
            chk("sat.ExecCount", {28'd0, ExecCount}, (6 + k + 1 > 15) ? 32'd15 : 32'(6 + k + 1));
        end
        chk("sat.SquashCount", {28'd0, SquashCount}, 32'd3);
        chk("sat.Flags", {28'd0, Flags}, 32'hF);
        chk("sat.UndefErr", {31'd0, UndefErr}, 32'd1);

        // Asynchronous reset between edges must clear everything at once.
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk("idle", 0, 0, 0, 4'h0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 4'd0, 4'd0));
        @(posedge clk);
        #1;
        check_all_zero("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
